// File: rtl/watch_chain_reader.sv
// -----------------------------------------------------------------------------
// watch_chain_reader
// Debugger-side master for one WatchChain scan chain. It generates TCK and
// the CaptureDR/ShiftDR controls, captures the chain once and then shifts all
// DATAWIDTH bits out, rebuilding them into a parallel word.
//
// Ports:
//   Clk        system clock, rising-edge
//   Reset      asynchronous active-high reset
//   iStart     one-cycle read request, accepted only when idle
//   oBusy      high while a read is in progress (CAPTURE/SHIFT)
//   oDone      one-cycle pulse, oData valid in the same cycle
//   oData      last captured chain word, bit 0 = first bit shifted out
//   oScanClk   TCK to the chain (registered)
//   oScanOut   serial data to the chain ScanIn, constant 0
//   iScanIn    serial data from the chain ScanOut
//   oScanCtrl  [1] ShiftDR, [0] CaptureDR
// -----------------------------------------------------------------------------
module watch_chain_reader #(
  parameter int DATAWIDTH = 133,
  parameter int CLKDIV    = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 iStart,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [DATAWIDTH-1:0] oData,
  output logic                 oScanClk,
  output logic                 oScanOut,
  input  logic                 iScanIn,
  output logic [1:0]           oScanCtrl
);

  localparam int BW = $clog2(DATAWIDTH + 1);
  localparam int DW = $clog2(CLKDIV + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATAWIDTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_SHIFT   = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e                 state_q,     state_d;
  logic [DW-1:0]          div_cnt_q,   div_cnt_d;
  logic [BW-1:0]          bit_cnt_q,   bit_cnt_d;
  logic [DATAWIDTH-1:0]   shreg_q,     shreg_d;
  logic [DATAWIDTH-1:0]   data_q,      data_d;
  logic                   scan_clk_q,  scan_clk_d;
  logic [1:0]             scan_ctrl_q, scan_ctrl_d;
  logic                   busy_q,      busy_d;
  logic                   done_q,      done_d;
  logic                   div_last_s;

  assign div_last_s = (div_cnt_q == DIV_LAST);

  // Next-state and registered-output logic for the read sequence.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    scan_clk_d  = scan_clk_q;
    scan_ctrl_d = scan_ctrl_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        div_cnt_d   = '0;
        scan_clk_d  = 1'b0;
        scan_ctrl_d = 2'b00;
        if (iStart) begin
          state_d     = S_CAPTURE;
          scan_ctrl_d = 2'b01;
          bit_cnt_d   = '0;
          shreg_d     = '0;
          busy_d      = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end

      S_CAPTURE: begin
        if (div_last_s) begin
          div_cnt_d  = '0;
          scan_clk_d = ~scan_clk_q;
          // End of the high phase: the capture edge has happened.
          if (scan_clk_q) begin
            state_d     = S_SHIFT;
            scan_ctrl_d = 2'b10;
            bit_cnt_d   = '0;
          end else begin
            state_d = S_CAPTURE;
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end

      S_SHIFT: begin
        if (div_last_s) begin
          div_cnt_d  = '0;
          scan_clk_d = ~scan_clk_q;
          if (!scan_clk_q) begin
            // Last cycle of the low phase: chain output is settled.
            for (int i = 0; i < DATAWIDTH; i++) begin
              shreg_d[i] = (bit_cnt_q == BW'(i)) ? iScanIn : shreg_q[i];
            end
            bit_cnt_d = bit_cnt_q + BW'(1);
          end else if (bit_cnt_q == BIT_LAST) begin
            // All bits sampled; the final rising edge only shifts the chain.
            state_d     = S_DONE;
            scan_ctrl_d = 2'b00;
            busy_d      = 1'b0;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end

      S_DONE: begin
        state_d     = S_IDLE;
        div_cnt_d   = '0;
        scan_clk_d  = 1'b0;
        scan_ctrl_d = 2'b00;
        busy_d      = 1'b0;
        data_d      = shreg_q;
        done_d      = 1'b1;
      end

      default: begin
        state_d     = S_IDLE;
        div_cnt_d   = '0;
        bit_cnt_d   = '0;
        scan_clk_d  = 1'b0;
        scan_ctrl_d = 2'b00;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      scan_clk_q  <= 1'b0;
      scan_ctrl_q <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      scan_clk_q  <= scan_clk_d;
      scan_ctrl_q <= scan_ctrl_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign oBusy     = busy_q;
  assign oDone     = done_q;
  assign oData     = data_q;
  assign oScanClk  = scan_clk_q;
  assign oScanCtrl = scan_ctrl_q;
  assign oScanOut  = 1'b0;

endmodule

// File: doc/watch_chain_reader.md
Name: watch_chain_reader

Overview:
- Debugger-side master for one WatchChain scan chain in the CPU.
- Generates the scan clock (TCK) and the CaptureDR/ShiftDR controls, then shifts out all DATAWIDTH chain bits and rebuilds them into a parallel word for the debug host.
- Two instances are used per CPU: one for the watch-data chain (oScanOut1) and one for the watch-signal chain (oScanOut2).

Parameters:
- DATAWIDTH, 133, chain length in bits; must be at least 1.
- CLKDIV, 2, scan-clock half-period in Clk cycles; must be at least 1.

Ports:
- Clk  input  1  system clock; everything is rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- iStart  input  1  one-cycle read request; accepted only in IDLE.
- oBusy  output  1  high from the cycle after iStart is accepted until DONE is exited.
- oDone  output  1  one-cycle pulse; oData is valid in the same cycle.
- oData  output  DATAWIDTH  last captured chain contents; bit 0 is the first bit shifted out.
- oScanClk  output  1  TCK to the chain.
- oScanOut  output  1  serial data to the chain ScanIn; tied to 0.
- iScanIn  input  1  serial data from the chain ScanOut.
- oScanCtrl  output  2  [1] ShiftDR, [0] CaptureDR.

Behaviour:
- Reset values: oBusy=0, oDone=0, oData=0, oScanClk=0, oScanCtrl=00, state=IDLE, all counters 0.
- Reset mid-operation aborts the read immediately; the partial word is discarded.
- Chain model: on each TCK rising edge, CaptureDR=1 loads the chain and ShiftDR=1 shifts it one place toward ScanOut. After capture, iScanIn already presents bit 0.
- Scan period: each TCK period is CLKDIV Clk cycles with oScanClk=0 (low phase), then CLKDIV Clk cycles with oScanClk=1 (high phase). oScanClk is a register output.
- Control changes: oScanCtrl changes only at the start of a low phase. It is therefore stable around every rising edge.
- Phase counter: divCnt counts 0..CLKDIV-1. It increments every Clk cycle outside IDLE/DONE. Its wrap toggles oScanClk.
- IDLE: oScanClk=0, oScanCtrl=00. iStart=1 causes a transition to CAPTURE on the next edge; oBusy=1 from that edge. iStart in any other state is ignored (not queued).
- CAPTURE: oScanCtrl=01 for exactly one TCK period. At the end of the high phase, go to SHIFT with bitCnt=0.
- SHIFT: oScanCtrl=10 for exactly DATAWIDTH TCK periods.
  - In the last Clk cycle of each low phase, sample iScanIn into shreg[bitCnt], then increment bitCnt.
  - After the high phase of period DATAWIDTH-1, go to DONE.
  - The final rising edge shifts the chain once more. This is harmless.
- DONE: one Clk cycle. oScanClk=0, oScanCtrl=00, oData<=shreg, oDone=1, oBusy=0 (registered, so low in this cycle). The next state is IDLE.
  - iStart asserted during DONE is ignored.
  - A new read may be accepted in IDLE on the following cycle.
- Latency: from the iStart edge to oDone = 2*CLKDIV*(DATAWIDTH+1)+1 Clk cycles.
- oData holds its value between reads and is updated only in DONE.
- Counter sizing: bitCnt width is $clog2(DATAWIDTH+1); divCnt width is $clog2(CLKDIV+1). Counters never wrap past their terminal values.

Test Plan:
- Reset: assert Reset asynchronously mid-cycle -> all outputs are 0 immediately, and the state is IDLE after release.
- Basic read: DATAWIDTH=8, CLKDIV=2, chain model loaded with 8'hA5, pulse iStart -> one CaptureDR rising edge, then 8 ShiftDR rising edges. oDone pulses 37 cycles after the iStart edge with oData=8'hA5, and oBusy is high for the 36 cycles in between.
- Timing: CLKDIV=1, DATAWIDTH=133, chain data = {32'hDEADBEEF, 5'h1F, 32'h00000013, 32'h00000004, 32'h00000008} -> oData matches exactly, and the checker sees no oScanCtrl change while oScanClk=1.
- Ignore while busy: pulse iStart again during SHIFT and during DONE -> no restart and no second oDone. A following iStart in IDLE produces a complete read.
- Reset mid-read: assert Reset during SHIFT at bitCnt=4 -> oData=0, oScanCtrl=00. A new iStart then reads the full correct value 8'h3C.
- Back-to-back reads: iStart in the first IDLE cycle after DONE, with the chain changed from 8'h01 to 8'h80 -> the two oDone pulses return 8'h01 then 8'h80, and oData holds 8'h01 between them.
